// File: rtl/ex_div_ctrl.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// optional signed mode, produces {remainder, quotient} for the HI/LO write path.
module ex_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               sgn_mode_q, sgn_mode_d;
  logic               neg1_q, neg1_d;
  logic               neg2_q, neg2_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quot, rem, a_abs, b_abs;

  // Partial remainder lives in work[2W:W+1]; work[2W-1:W] is that remainder
  // shifted left with the next dividend bit, i.e. the trial minuend.
  assign diff  = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, dvsr_q};
  assign quot  = work_q[WIDTH-1:0];
  assign rem   = work_q[2*WIDTH:WIDTH+1];
  assign a_abs = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign b_abs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    sgn_mode_d = sgn_mode_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = '0;
            work_d     = {{WIDTH{1'b0}}, a_abs, 1'b0};
            dvsr_d     = b_abs;
            sgn_mode_d = signed_i;
            neg1_d     = signed_i & opdata1_i[WIDTH-1];
            neg2_d     = signed_i & opdata2_i[WIDTH-1];
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          // Quotient truncates toward zero; remainder follows the dividend sign.
          result_d[WIDTH-1:0]       = (neg1_q ^ neg2_q) ? -quot : quot;
          result_d[2*WIDTH-1:WIDTH] = neg1_q ? -rem : rem;
          state_d = S_END;
        end else begin
          if (diff[WIDTH]) work_d = {work_q[2*WIDTH-1:0], 1'b0};
          else             work_d = {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (annul_i || !start_i) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      dvsr_q     <= '0;
      sgn_mode_q <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      sgn_mode_q <= sgn_mode_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_q   <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == S_END);
  assign busy_o   = (state_q == S_ON) || (state_q == S_BYZERO);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed plus randomized bench for ex_div_ctrl against a plain-arithmetic divide model.
module tb_ex_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;

  int checks = 0;
  int failures = 0;

  ex_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic so the signed overflow case wraps naturally.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit toggle);
    int n;
    logic [63:0] held;
    signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    step();
    n = 1;
    chk({tag, "_busy1"}, busy_o, 1'b1);
    while (!ready_o && n < 100) begin
      if (toggle) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~signed_i;
      end
      step();
      n++;
      if (n == 2 && b != 0) chk({tag, "_on_busy"}, {busy_o, ready_o}, 2'b10);
    end
    chk({tag, "_lat"}, 64'(n), (b == 0) ? 64'd2 : 64'd34);
    chk({tag, "_res"}, result_o, exp);
    step();
    chk({tag, "_hold_end"}, {busy_o, ready_o}, 2'b01);
    held = result_o;
    start_i = 1'b0;
    step();
    chk({tag, "_drop"}, {busy_o, ready_o, result_o}, {2'b00, held});
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs, seen;
    int          n;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step(); step();
    chk("reset", {busy_o, ready_o, result_o}, 66'd0);
    rst = 1'b0;
    step();

    run_div("u100_7",  1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    run_div("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_div("s7_-2",   1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_div("divzero", 1'b0, 32'h1234, 32'd0, 64'd0, 1'b0);
    run_div("s_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    run_div("u_max",   1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0);
    run_div("u9_4",    1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 1'b0);

    // Annul during the 10th ON cycle.
    signed_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
    step();
    n = 1;
    while (n < 10) begin step(); n++; end
    annul_i = 1'b1;
    step();
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_idle", {busy_o, ready_o, result_o}, {2'b00, 64'h00000001_00000002});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin step(); if (ready_o) seen = 1'b1; end
    chk("annul_noready", seen, 1'b0);
    run_div("u5_5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, 1'b0);

    // Synchronous reset during the 20th ON cycle.
    signed_i = 1'b0; opdata1_i = 32'd777; opdata2_i = 32'd5; start_i = 1'b1;
    step();
    n = 1;
    while (n < 20) begin step(); n++; end
    rst = 1'b1;
    step();
    rst = 1'b0; start_i = 1'b0;
    chk("midrst", {busy_o, ready_o, result_o}, 66'd0);
    step();

    run_div("u1000_3_tog", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b1);

    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (rb == 0 && $urandom_range(0, 1) == 1) rb = 32'd3;
      run_div("rand", rs, ra, rb, model(rs, ra, rb), 1'(k & 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_div_ctrl.md
Name: ex_div_ctrl

Overview:
Multi-cycle divide sequencer attached to the EX stage. It accepts a DIV/DIVU request from EX, latches the operands, runs a one-bit-per-cycle restoring division under FSM control, and presents a 64-bit {remainder, quotient} result for the HI/LO write path. While it is busy it drives busy_o, which EX turns into a pipeline stall request. annul_i aborts an in-flight divide.

Parameters:
WIDTH, 32, operand width (equals the register bus width).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
start_i  in  1  divide request from EX; held high by EX until ready_o has been consumed
signed_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i
opdata1_i  in  WIDTH  dividend; sampled with start_i
opdata2_i  in  WIDTH  divisor; sampled with start_i
annul_i  in  1  abort the current operation (flush or exception)
result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
ready_o  out  1  result_o valid
busy_o  out  1  high in ON and BYZERO; EX stalls on it

Behaviour:
- Reset: state=IDLE, counter=0, result_o=0, ready_o=0, busy_o=0. Any cycle with rst=1 forces these values, including mid-operation; latched operands are discarded.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - Enter ON or BYZERO only when start_i=1 and annul_i=0.
  - Divisor=0 -> BYZERO.
  - Otherwise -> ON, with counter=0 and the operands latched.
  - Signed mode latches the absolute values and records both operand signs.
- BYZERO: after 1 cycle, go to END with result_o=0.
- ON:
  - Each cycle performs one restoring step on a (2*WIDTH+1)-bit working register: trial-subtract the divisor from the upper half, shift left, insert the quotient bit, counter+1.
  - When counter==WIDTH, perform the sign fix-up and go to END; no subtraction happens in that cycle.
  - Sign fix-up (signed mode only):
    - Quotient is negated if the operand signs differ, so it truncates toward zero.
    - Remainder is negated if the dividend is negative, so its sign follows the dividend.
  - annul_i=1 in any ON cycle -> IDLE next cycle; result_o is unchanged and ready_o stays 0.
  - start_i dropping during ON is ignored; only annul_i aborts.
- END:
  - ready_o=1 and result_o holds the result.
  - Stay in END while start_i=1.
  - start_i=0 -> IDLE next cycle, with ready_o=0 in that cycle. result_o holds its value until the next END.
  - annul_i in END -> IDLE.
- Latency, with start sampled at edge t:
  - Nonzero divisor: ON for cycles t+1..t+WIDTH+1; ready_o first high in cycle t+WIDTH+2 (34 cycles for WIDTH=32).
  - Zero divisor: ready_o first high at t+2.
- busy_o = (state==ON) or (state==BYZERO).
- Operand changes on the inputs after sampling have no effect on the running operation.
- Overflow: signed most-negative/-1 wraps to quotient=0x80000000, remainder=0. No trap is raised.
- Back-to-back operations: a new start_i is accepted only from IDLE. EX must drop start_i for at least one cycle between operations.

Test Plan:
- Unsigned 100/7, start held -> ready_o at t+34; result_o={0x00000002, 0x0000000E}. Drop start -> ready_o=0 next cycle, state IDLE.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x1234/0 -> busy_o high for exactly 1 cycle; ready_o at t+2; result_o=0.
- Annul at the 10th ON cycle -> IDLE next cycle; busy_o=0; ready_o never asserts. A following start 5/5 completes with quotient 1, remainder 0.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Assert rst at the 20th ON cycle -> next cycle result_o=0, ready_o=0, busy_o=0. Operand toggling during ON (no reset) does not alter a 1000/3 result of quotient 333, remainder 1.
